// File: rtl/ocf_burst_reader.sv
// rtl/ocf_burst_reader.sv - Avalon-MM burst read initiator for the on-chip flash IP
//
// Accepts a read job (start word address, word count), polls the OCF status
// register until the flash reports idle, then reads the range in data-port
// bursts of at most MAX_BURST words and streams every returned word out.
//
// Ports
//   clock, reset_n             clock, asynchronous active-low reset
//   req_valid/req_ready        job handshake; req_addr/req_len latched on accept
//   dout_valid/dout_data       one strobe per returned word, no backpressure
//   busy/done/err              job status; done/err are one-cycle pulses
//   avmm_csr_*                 status-register read port (write side held 0)
//   avmm_data_*                burst read port (write side held 0)
module ocf_burst_reader #(
  parameter int MAX_BURST = 8,
  parameter int POLL_MAX  = 1024,
  parameter int BEAT_TO   = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [17:0] req_addr,
  input  logic [17:0] req_len,
  output logic        dout_valid,
  output logic [31:0] dout_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        avmm_csr_addr,
  output logic        avmm_csr_read,
  output logic        avmm_csr_write,
  output logic [31:0] avmm_csr_writedata,
  input  logic [31:0] avmm_csr_readdata,
  output logic [17:0] avmm_data_addr,
  output logic        avmm_data_read,
  output logic        avmm_data_write,
  output logic [31:0] avmm_data_writedata,
  output logic [3:0]  avmm_data_burstcount,
  input  logic        avmm_data_waitrequest,
  input  logic [31:0] avmm_data_readdata,
  input  logic        avmm_data_readdatavalid
);

  localparam int PW = $clog2(POLL_MAX + 1);
  localparam int IW = $clog2(BEAT_TO + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CSR_RD, S_CSR_CHK, S_ISSUE, S_DATA, S_DONE, S_ERR
  } state_t;

  state_t          r_state, w_next;
  logic [17:0]     r_cur_addr;
  logic [17:0]     r_remaining;
  logic [3:0]      r_beats;
  logic [PW-1:0]   r_poll_cnt;
  logic [IW-1:0]   r_idle_cnt;
  logic            r_dout_valid;
  logic [31:0]     r_dout_data;

  logic            w_accept;
  logic [18:0]     w_end;
  logic            w_range_bad;
  logic            w_csr_idle;
  logic            w_poll_last;
  logic            w_beat;
  logic            w_idle_last;
  logic [3:0]      w_burst;
  logic            w_unused_csr;

  assign w_accept    = req_valid && (r_state == S_IDLE);
  // 19-bit end address so a range ending exactly at 2^18 is legal and anything past it is caught.
  assign w_end       = {1'b0, req_addr} + {1'b0, req_len};
  assign w_range_bad = (req_len == 18'd0) || (w_end > 19'h40000);
  assign w_csr_idle  = (avmm_csr_readdata[1:0] == 2'b00);
  assign w_poll_last = (r_poll_cnt == PW'(POLL_MAX - 1));
  assign w_beat      = (r_state == S_DATA) && avmm_data_readdatavalid;
  assign w_idle_last = (r_idle_cnt == IW'(BEAT_TO - 1));
  assign w_burst     = (r_remaining > 18'(MAX_BURST)) ? 4'(MAX_BURST) : r_remaining[3:0];
  assign w_unused_csr = ^avmm_csr_readdata[31:2];

  assign avmm_csr_addr       = 1'b0;
  assign avmm_csr_write      = 1'b0;
  assign avmm_csr_writedata  = 32'd0;
  assign avmm_data_write     = 1'b0;
  assign avmm_data_writedata = 32'd0;
  assign dout_valid          = r_dout_valid;
  assign dout_data           = r_dout_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next               = r_state;
    req_ready            = 1'b0;
    busy                 = 1'b0;
    done                 = 1'b0;
    err                  = 1'b0;
    avmm_csr_read        = 1'b0;
    avmm_data_read       = 1'b0;
    avmm_data_addr       = 18'd0;
    avmm_data_burstcount = 4'd0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) w_next = w_range_bad ? S_ERR : S_CSR_RD;
      end
      S_CSR_RD: begin
        busy          = 1'b1;
        avmm_csr_read = 1'b1;
        w_next        = S_CSR_CHK;
      end
      S_CSR_CHK: begin
        busy = 1'b1;
        if (w_csr_idle)       w_next = S_ISSUE;
        else if (w_poll_last) w_next = S_ERR;
        else                  w_next = S_CSR_RD;
      end
      S_ISSUE: begin
        // Command fields come straight from registers, so they cannot move during a stall.
        busy                 = 1'b1;
        avmm_data_read       = 1'b1;
        avmm_data_addr       = r_cur_addr;
        avmm_data_burstcount = w_burst;
        if (!avmm_data_waitrequest) w_next = S_DATA;
      end
      S_DATA: begin
        busy = 1'b1;
        // r_remaining was already reduced when this burst was issued.
        if (w_beat) begin
          if (r_beats == 4'd1) w_next = (r_remaining == 18'd0) ? S_DONE : S_ISSUE;
        end else if (w_idle_last) begin
          w_next = S_ERR;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR: begin
        err    = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cur_addr   <= 18'd0;
      r_remaining  <= 18'd0;
      r_beats      <= 4'd0;
      r_poll_cnt   <= '0;
      r_idle_cnt   <= '0;
      r_dout_valid <= 1'b0;
      r_dout_data  <= 32'd0;
    end else begin
      r_dout_valid <= w_beat;
      if (w_beat) r_dout_data <= avmm_data_readdata;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cur_addr  <= req_addr;
            r_remaining <= req_len;
            r_poll_cnt  <= '0;
          end
        end
        S_CSR_CHK: begin
          if (!w_csr_idle) r_poll_cnt <= r_poll_cnt + 1'b1;
        end
        S_ISSUE: begin
          if (!avmm_data_waitrequest) begin
            r_beats     <= w_burst;
            r_cur_addr  <= r_cur_addr + 18'(w_burst);
            r_remaining <= r_remaining - 18'(w_burst);
            r_idle_cnt  <= '0;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            r_beats    <= r_beats - 4'd1;
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ocf_burst_reader.sv
// tb/tb_ocf_burst_reader.sv - directed self-checking bench for ocf_burst_reader
module tb_ocf_burst_reader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [17:0] req_addr;
  logic [17:0] req_len;
  logic        dout_valid;
  logic [31:0] dout_data;
  logic        busy, done, err;
  logic        avmm_csr_addr, avmm_csr_read, avmm_csr_write;
  logic [31:0] avmm_csr_writedata, avmm_csr_readdata;
  logic [17:0] avmm_data_addr;
  logic        avmm_data_read, avmm_data_write;
  logic [31:0] avmm_data_writedata;
  logic [3:0]  avmm_data_burstcount;
  logic        avmm_data_waitrequest;
  logic [31:0] avmm_data_readdata;
  logic        avmm_data_readdatavalid;

  ocf_burst_reader #(.MAX_BURST(8), .POLL_MAX(1024), .BEAT_TO(256)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .dout_valid(dout_valid), .dout_data(dout_data),
    .busy(busy), .done(done), .err(err),
    .avmm_csr_addr(avmm_csr_addr), .avmm_csr_read(avmm_csr_read),
    .avmm_csr_write(avmm_csr_write), .avmm_csr_writedata(avmm_csr_writedata),
    .avmm_csr_readdata(avmm_csr_readdata),
    .avmm_data_addr(avmm_data_addr), .avmm_data_read(avmm_data_read),
    .avmm_data_write(avmm_data_write), .avmm_data_writedata(avmm_data_writedata),
    .avmm_data_burstcount(avmm_data_burstcount),
    .avmm_data_waitrequest(avmm_data_waitrequest),
    .avmm_data_readdata(avmm_data_readdata),
    .avmm_data_readdatavalid(avmm_data_readdatavalid)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_of(input logic [17:0] a);
    return {a[15:0], a[15:0]};
  endfunction

  // bench-owned knobs
  int   busy_polls = 0;
  int   csr_base   = 0;
  logic stall_en   = 1'b0;
  int   stall_cmd  = 0;
  logic no_resp    = 1'b0;

  // flash model state
  int          csr_cnt = 0;
  int          cmd_cnt = 0;
  int          stall_run = 0;
  int          unstable = 0;
  logic [17:0] beat_addr;
  logic [3:0]  beats_left;
  logic        rec_valid;
  logic [17:0] rec_addr;
  logic [3:0]  rec_bc;
  logic [17:0] cmd_addr_q[$];
  logic [3:0]  cmd_bc_q[$];

  assign avmm_csr_readdata = ((csr_cnt - csr_base) <= busy_polls) ? 32'h19 : 32'h18;
  assign avmm_data_waitrequest = avmm_data_read && stall_en && (cmd_cnt == stall_cmd) && (stall_run < 3);

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beats_left              <= 4'd0;
      beat_addr               <= 18'd0;
      avmm_data_readdatavalid <= 1'b0;
      avmm_data_readdata      <= 32'd0;
      stall_run               <= 0;
      rec_valid               <= 1'b0;
    end else begin
      if (avmm_csr_read) csr_cnt <= csr_cnt + 1;
      avmm_data_readdatavalid <= 1'b0;
      if (beats_left != 4'd0 && !no_resp) begin
        avmm_data_readdatavalid <= 1'b1;
        avmm_data_readdata      <= word_of(beat_addr);
        beat_addr               <= beat_addr + 18'd1;
        beats_left              <= beats_left - 4'd1;
      end
      if (avmm_data_read && avmm_data_waitrequest) begin
        stall_run <= stall_run + 1;
        if (rec_valid && (avmm_data_addr != rec_addr || avmm_data_burstcount != rec_bc))
          unstable <= unstable + 1;
        rec_valid <= 1'b1;
        rec_addr  <= avmm_data_addr;
        rec_bc    <= avmm_data_burstcount;
      end
      if (avmm_data_read && !avmm_data_waitrequest) begin
        if (rec_valid && (avmm_data_addr != rec_addr || avmm_data_burstcount != rec_bc))
          unstable <= unstable + 1;
        rec_valid  <= 1'b0;
        stall_run  <= 0;
        cmd_cnt    <= cmd_cnt + 1;
        beat_addr  <= avmm_data_addr;
        beats_left <= avmm_data_burstcount;
        cmd_addr_q.push_back(avmm_data_addr);
        cmd_bc_q.push_back(avmm_data_burstcount);
      end
    end
  end

  // output monitor
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          rd_hi = 0;
  logic [31:0] got_q[$];

  always @(negedge clock) begin
    if (dout_valid)     got_q.push_back(dout_data);
    if (done)           done_cnt++;
    if (err)            err_cnt++;
    if (avmm_data_read) rd_hi++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int s_done, s_err, s_csr, s_cmd, s_got, s_rdhi, s_unst;

  task automatic snap();
    s_done   = done_cnt;
    s_err    = err_cnt;
    s_csr    = csr_cnt;
    s_cmd    = cmd_cnt;
    s_got    = got_q.size();
    s_rdhi   = rd_hi;
    s_unst   = unstable;
    csr_base = csr_cnt;
  endtask

  task automatic start_job(input logic [17:0] a, input logic [17:0] l);
    snap();
    @(negedge clock);
    req_addr  = a;
    req_len   = l;
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_end(input int bound);
    int c = 0;
    while ((done_cnt + err_cnt) == (s_done + s_err) && c < bound) begin
      @(negedge clock);
      c++;
    end
    if (c >= bound) check("job_end_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clock);
  endtask

  task automatic check_words(input logic [17:0] a, input int len);
    logic [17:0] wa;
    check("nwords", got_q.size() - s_got, len);
    for (int i = 0; i < len; i++) begin
      wa = a + 18'(i);
      if (s_got + i < got_q.size()) check("word", got_q[s_got + i], word_of(wa));
    end
  endtask

  task automatic check_outcome(input int exp_done, input int exp_err, input int exp_csr, input int exp_cmd);
    check("done_cnt", done_cnt - s_done, exp_done);
    check("err_cnt",  err_cnt - s_err,   exp_err);
    check("csr_reads", csr_cnt - s_csr,  exp_csr);
    check("data_cmds", cmd_cnt - s_cmd,  exp_cmd);
  endtask

  initial begin
    int c;
    logic [3:0] bc_exp [3];
    bc_exp[0] = 4'd8; bc_exp[1] = 4'd8; bc_exp[2] = 4'd4;
    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0;
    repeat (3) @(negedge clock);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_csr_read", avmm_csr_read, 0);
    check("rst_data_read", avmm_data_read, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_burstcount", avmm_data_burstcount, 0);
    check("rst_writes", {avmm_csr_write, avmm_data_write, avmm_csr_addr}, 0);
    reset_n = 1'b1;

    // single word
    start_job(18'h00010, 18'd1);
    wait_end(200);
    check_outcome(1, 0, 1, 1);
    check("t1_bc", cmd_bc_q[s_cmd], 1);
    check("t1_addr", cmd_addr_q[s_cmd], 18'h10);
    check_words(18'h00010, 1);
    check("t1_idle_ready", req_ready, 1);

    // 20 words -> 8/8/4
    start_job(18'h00100, 18'd20);
    wait_end(500);
    check_outcome(1, 0, 1, 3);
    for (int k = 0; k < 3; k++) begin
      if (s_cmd + k < cmd_bc_q.size()) begin
        check("t2_burst_addr", cmd_addr_q[s_cmd + k], 18'h100 + 18'(8 * k));
        check("t2_burst_bc", cmd_bc_q[s_cmd + k], bc_exp[k]);
      end
    end
    check_words(18'h00100, 20);

    // flash busy for 5 polls
    busy_polls = 5;
    start_job(18'h00040, 18'd3);
    wait_end(300);
    check_outcome(1, 0, 6, 1);
    check_words(18'h00040, 3);

    // flash stuck busy
    busy_polls = 100000;
    start_job(18'h00040, 18'd3);
    wait_end(3000);
    check_outcome(0, 1, 1024, 0);
    busy_polls = 0;

    // range errors and the top-of-flash boundary
    start_job(18'h3FFF0, 18'h20);
    wait_end(50);
    check_outcome(0, 1, 0, 0);
    start_job(18'h00050, 18'h0);
    wait_end(50);
    check_outcome(0, 1, 0, 0);
    start_job(18'h3FFF0, 18'h10);
    wait_end(300);
    check_outcome(1, 0, 1, 2);
    check_words(18'h3FFF0, 16);

    // waitrequest stall on second burst
    stall_en  = 1'b1;
    stall_cmd = cmd_cnt + 1;
    start_job(18'h00100, 18'd20);
    wait_end(500);
    stall_en = 1'b0;
    check_outcome(1, 0, 1, 3);
    check("t5_unstable", unstable - s_unst, 0);
    check("t5_read_cycles", rd_hi - s_rdhi, 6);
    check_words(18'h00100, 20);

    // reset while burst 2 is being offered
    stall_en  = 1'b1;
    stall_cmd = cmd_cnt + 1;
    start_job(18'h00100, 18'd20);
    c = 0;
    while (!(avmm_data_read && avmm_data_waitrequest) && c < 200) begin
      @(negedge clock);
      c++;
    end
    if (c >= 200) check("t6_stall_seen_timeout", 0, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_data_read", avmm_data_read, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_req_ready", req_ready, 1);
    check("t6_rst_dout_valid", dout_valid, 0);
    @(negedge clock);
    reset_n  = 1'b1;
    stall_en = 1'b0;
    repeat (3) @(negedge clock);
    check("t6_no_done", done_cnt - s_done, 0);
    check("t6_no_err", err_cnt - s_err, 0);
    start_job(18'h00200, 18'd10);
    wait_end(300);
    check_outcome(1, 0, 1, 2);
    check_words(18'h00200, 10);

    // no returned data -> beat timeout
    no_resp = 1'b1;
    start_job(18'h00020, 18'd2);
    c = 0;
    while (cmd_cnt == s_cmd && c < 100) begin
      @(negedge clock);
      c++;
    end
    c = 0;
    while (err_cnt == s_err && c < 400) begin
      @(negedge clock);
      c++;
    end
    check("t6_beat_to_window", (c >= 250 && c <= 262), 1);
    repeat (3) @(negedge clock);
    check_outcome(0, 1, 1, 1);
    check("t6_no_words", got_q.size() - s_got, 0);
    no_resp = 1'b0;

    // stale beats now arrive while idle and must be ignored
    start_job(18'h00030, 18'd1);
    wait_end(200);
    check_outcome(1, 0, 1, 1);
    check_words(18'h00030, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
